// File: rtl/vm_input_pkg.sv
// rtl/vm_input_pkg.sv - shared constants and types for the vending-machine input conditioner
//
// Purpose : coin credit constants, channel numbering, front-end FSM states and a
//           small helper used to size the shared debounce/repeat counters.
// Ports   : none (package)
package vm_input_pkg;

    localparam logic [4:0] COIN_1  = 5'd1;
    localparam logic [4:0] COIN_5  = 5'd5;
    localparam logic [4:0] COIN_10 = 5'd10;
    localparam logic [4:0] COIN_20 = 5'd20;

    localparam int NUM_CH = 7;

    // Bit position of each input channel inside the top-level raw/stable/rise vectors.
    typedef enum logic [2:0] {
        CH_L   = 3'd0,
        CH_R   = 3'd1,
        CH_C   = 3'd2,
        CH_SW0 = 3'd3,
        CH_SW1 = 3'd4,
        CH_SW2 = 3'd5,
        CH_SW3 = 3'd6
    } channel_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vm_debounce_cell.sv
// rtl/vm_debounce_cell.sv - one input channel: 2-flop sync, debounce counter, stable level, rise detect
//
// Purpose : turns one raw asynchronous, bouncy input into a clean stable level and a
//           one-cycle rise indication (stable went 0->1 on the previous edge).
// Ports   : clk, rst        - system clock, async active-high reset
//           i_raw           - raw input
//           i_init_load     - while high, stable follows the synchronised input silently
//           o_stable        - debounced level
//           o_rise          - high for one cycle after stable rises
module vm_debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_init_load,
    output logic o_stable,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_init_load) begin
                // Load both copies so no rise is seen when leaving init.
                r_stable   <= r_sync2;
                r_stable_d <= r_sync2;
                r_cnt      <= '0;
            end else begin
                r_stable_d <= r_stable;
                if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_stable_d;

endmodule

// File: rtl/vm_input_conditioner.sv
// rtl/vm_input_conditioner.sv - button/coin front end: debounce, press pulses, coin encode and inhibit
//
// Purpose : debounces L/R/C buttons and four coin switches, emits one-clock registered
//           pulses per clean press, encodes coins (highest value wins) and rejects coins
//           while coin_inhibit is high. Optional auto-repeat on L/R under the
//           BUTTON_REPEAT_EN macro.
// Ports   : clk, rst (async active-high)
//           L_button, R_button, C_button, switch[3:0], coin_inhibit - inputs
//           L_pulse, R_pulse, C_pulse                               - press pulses
//           coin_valid, coin_value[4:0], coin_reject, coin_conflict - coin pulses
//           ready                                                   - high in RUN
module vm_input_conditioner
    import vm_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 150000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       L_button,
    input  logic       R_button,
    input  logic       C_button,
    input  logic [3:0] switch,
    input  logic       coin_inhibit,
    output logic       L_pulse,
    output logic       R_pulse,
    output logic       C_pulse,
    output logic       coin_valid,
    output logic [4:0] coin_value,
    output logic       coin_reject,
    output logic       coin_conflict,
    output logic       ready
);

    localparam int CNT_W  = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam int INIT_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);

    localparam int IL = int'(CH_L);
    localparam int IR = int'(CH_R);
    localparam int IC = int'(CH_C);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_stable;
    logic [NUM_CH-1:0] w_rise;
    logic [3:0]        w_sw_rise;
    logic [4:0]        w_coin_val;
    logic              w_coin_any;
    logic              w_coin_multi;
    logic [1:0]        w_rep_fire;
    logic              w_init_load;
    logic              w_run;
    state_e            r_state;
    state_e            w_state_next;
    logic [INIT_W-1:0] r_init_cnt;

    logic       r_l_pulse, r_r_pulse, r_c_pulse;
    logic       r_coin_valid, r_coin_reject, r_coin_conflict;
    logic [4:0] r_coin_value;

    assign w_raw = {switch, C_button, R_button, L_button};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        vm_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .i_raw       (w_raw[g]),
            .i_init_load (w_init_load),
            .o_stable    (w_stable[g]),
            .o_rise      (w_rise[g])
        );
    end

    // INIT lasts DEBOUNCE_CYCLES+2 clocks so every synchroniser has settled before RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == INIT && r_init_cnt != INIT_LAST) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == INIT && r_init_cnt == INIT_LAST) begin
            w_state_next = RUN;
        end
    end

    always_comb begin
        w_init_load = (r_state == INIT);
        w_run       = (r_state == RUN);
    end

    assign ready = w_run;

    assign w_sw_rise = w_rise[NUM_CH-1:int'(CH_SW0)];

    always_comb begin
        w_coin_val = '0;
        if (w_sw_rise[3])      w_coin_val = COIN_20;
        else if (w_sw_rise[2]) w_coin_val = COIN_10;
        else if (w_sw_rise[1]) w_coin_val = COIN_5;
        else if (w_sw_rise[0]) w_coin_val = COIN_1;
        w_coin_any   = |w_sw_rise;
        // More than one bit set: clearing the lowest set bit leaves something.
        w_coin_multi = (w_sw_rise & (w_sw_rise - 4'd1)) != 4'd0;
    end

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       r_rep_act;
    logic [1:0]       r_rep_first;
    logic [CNT_W-1:0] r_rep_cnt [2];
    logic [1:0]       w_rep_hold;
    logic             w_both_held;

    // Index 0 = L, 1 = R. Holding both buttons cancels repeat on both.
    always_comb begin
        w_both_held = w_stable[IL] & w_stable[IR];
        w_rep_hold  = {w_stable[IR], w_stable[IL]} & {2{w_run & ~w_both_held}};
        for (int i = 0; i < 2; i++) begin
            w_rep_fire[i] = w_rep_hold[i] & r_rep_act[i] &
                            (r_rep_cnt[i] == (r_rep_first[i] ? REP_DLY_LAST : REP_PER_LAST));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_act   <= '0;
            r_rep_first <= '1;
            for (int i = 0; i < 2; i++) r_rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!w_rep_hold[i]) begin
                    r_rep_act[i]   <= 1'b0;
                    r_rep_first[i] <= 1'b1;
                    r_rep_cnt[i]   <= '0;
                end else if (w_rise[i]) begin
                    // Timer starts on the edge that registers the press pulse.
                    r_rep_act[i]   <= 1'b1;
                    r_rep_first[i] <= 1'b1;
                    r_rep_cnt[i]   <= '0;
                end else if (w_rep_fire[i]) begin
                    r_rep_first[i] <= 1'b0;
                    r_rep_cnt[i]   <= '0;
                end else if (r_rep_act[i]) begin
                    r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_stable;
    assign w_unused_stable = ^w_stable;
    assign w_rep_fire      = 2'b00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l_pulse       <= 1'b0;
            r_r_pulse       <= 1'b0;
            r_c_pulse       <= 1'b0;
            r_coin_valid    <= 1'b0;
            r_coin_reject   <= 1'b0;
            r_coin_conflict <= 1'b0;
            r_coin_value    <= '0;
        end else begin
            r_l_pulse       <= w_run & (w_rise[IL] | w_rep_fire[0]);
            r_r_pulse       <= w_run & (w_rise[IR] | w_rep_fire[1]);
            r_c_pulse       <= w_run & w_rise[IC];
            r_coin_valid    <= w_run & w_coin_any & ~coin_inhibit;
            r_coin_reject   <= w_run & w_coin_any & coin_inhibit;
            r_coin_conflict <= w_run & w_coin_multi;
            r_coin_value    <= w_run ? w_coin_val : 5'd0;
        end
    end

    assign L_pulse       = r_l_pulse;
    assign R_pulse       = r_r_pulse;
    assign C_pulse       = r_c_pulse;
    assign coin_valid    = r_coin_valid;
    assign coin_reject   = r_coin_reject;
    assign coin_conflict = r_coin_conflict;
    assign coin_value    = r_coin_value;

endmodule

// File: tb/tb_vm_input_conditioner.sv
// tb/tb_vm_input_conditioner.sv - scoreboard bench for vm_input_conditioner
module tb_vm_input_conditioner;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int LAT = DC + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       L_button = 1'b0, R_button = 1'b0, C_button = 1'b0;
    logic [3:0] switch = 4'b0100;
    logic       coin_inhibit = 1'b0;
    logic       L_pulse, R_pulse, C_pulse, coin_valid, coin_reject, coin_conflict, ready;
    logic [4:0] coin_value;

    vm_input_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .L_button      (L_button),
        .R_button      (R_button),
        .C_button      (C_button),
        .switch        (switch),
        .coin_inhibit  (coin_inhibit),
        .L_pulse       (L_pulse),
        .R_pulse       (R_pulse),
        .C_pulse       (C_pulse),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .coin_reject   (coin_reject),
        .coin_conflict (coin_conflict),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         cyc;
        logic [5:0] flags;   // {L, R, C, valid, reject, conflict}
        logic [4:0] value;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got 0x%0h required 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic expect_at(input int c, input logic [5:0] flags, input logic [4:0] value);
        exp_t e;
        e.cyc   = c;
        e.flags = flags;
        e.value = value;
        q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int all_outputs();
        return {L_pulse, R_pulse, C_pulse, coin_valid, coin_reject, coin_conflict, coin_value, ready};
    endfunction

    // Monitor: every presented pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!done && (L_pulse | R_pulse | C_pulse | coin_valid | coin_reject | coin_conflict)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse at cyc %0d: got flags %b value %0d required none",
                         cyc, {L_pulse, R_pulse, C_pulse, coin_valid, coin_reject, coin_conflict}, coin_value);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_fields",
                      {L_pulse, R_pulse, C_pulse, coin_valid, coin_reject, coin_conflict, coin_value},
                      {e.flags, e.value});
            end
        end
    end

    initial begin
        int t;
        int p;
        int r0;

        // 1. reset with switch[2] already high: adopted silently, ready after DC+2 clocks
        wait_n(3);
        check("reset_outputs", all_outputs(), 0);
        rst = 1'b0;
        r0  = cyc;
        wait_n(5);
        check("init_ready_low", ready, 0);
        wait_n(1);
        check("init_ready_high", ready, 1);
        wait_n(4);
        switch[2] = 1'b0;
        wait_n(12);

        // 2. L with a 1-clock bounce, then a 3-clock R glitch
        L_button = 1'b1;
        wait_n(2);
        L_button = 1'b0;
        wait_n(1);
        L_button = 1'b1;
        expect_at(cyc + LAT, 6'b100000, 5'd0);
        wait_n(15);
        L_button = 1'b0;
        wait_n(12);
        R_button = 1'b1;
        wait_n(3);
        R_button = 1'b0;
        wait_n(12);

        // 3. accepted 5 coin, then rejected 20 coin
        switch[1] = 1'b1;
        expect_at(cyc + LAT, 6'b000100, 5'd5);
        wait_n(12);
        switch[1] = 1'b0;
        wait_n(12);
        coin_inhibit = 1'b1;
        switch[3] = 1'b1;
        expect_at(cyc + LAT, 6'b000010, 5'd20);
        wait_n(12);
        coin_inhibit = 1'b0;
        switch[3] = 1'b0;
        wait_n(12);

        // 4. 1 and 10 together: 10 wins, conflict flagged
        switch[0] = 1'b1;
        switch[2] = 1'b1;
        expect_at(cyc + LAT, 6'b000101, 5'd10);
        wait_n(12);
        switch = 4'b0000;
        wait_n(12);

        // 5. R held: press pulse plus repeats while the debounced level stays high
        R_button = 1'b1;
        t = cyc;
        p = t + LAT;
        expect_at(p, 6'b010000, 5'd0);
`ifdef BUTTON_REPEAT_EN
        for (int k = RD; k <= 22; k += RP) expect_at(p + k, 6'b010000, 5'd0);
`endif
        wait_n(25);
        R_button = 1'b0;
        wait_n(20);

        // 6. reset during a C debounce: no pulse, outputs cleared, fresh init
        C_button = 1'b1;
        wait_n(2);
        rst = 1'b1;
        wait_n(1);
        check("midrst_outputs", all_outputs(), 0);
        wait_n(2);
        check("midrst_outputs_held", all_outputs(), 0);
        rst = 1'b0;
        wait_n(5);
        check("reinit_ready_low", ready, 0);
        wait_n(1);
        check("reinit_ready_high", ready, 1);
        wait_n(10);
        C_button = 1'b0;
        wait_n(12);
        C_button = 1'b1;
        expect_at(cyc + LAT, 6'b001000, 5'd0);
        wait_n(12);
        C_button = 1'b0;
        wait_n(12);

        done = 1'b1;
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
